audio_dac_serializer: RTL and testbench

AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

---
 rtl/audio_dac_serializer.sv | 231 +++++++++++++++++++++++
 tb/tb_audio_dac_serializer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: queues 24-bit stereo pairs and shifts them out as I2S to a codec DAC.
// Latency: a queued pair starts on the next synchronized DACLRCK falling edge; MSB on the BCLK fall after it.
// Backpressure: write_ready drops when the FIFO holds DEPTH pairs; an empty FIFO at frame start sends zeros.
//
// Ports:
//   CLOCK_50         system clock, all state on its rising edge
//   reset_n          asynchronous active-low reset
//   write            push request, accepted only while write_ready is high
//   writedata_left   24-bit left sample (two's complement)
//   writedata_right  24-bit right sample (two's complement)
//   write_ready      FIFO has room for one more pair
//   AUD_BCLK         codec bit clock (asynchronous, synchronized internally)
//   AUD_DACLRCK      codec frame clock, low = left, high = right (asynchronous)
//   AUD_DACDAT       serial DAC data, changes after synchronized BCLK falling edges
//   underflow        sticky: some frame started with nothing queued; cleared only by reset
//   underflow_count  number of such frames, saturating at 16'hFFFF
//
// Build option: define DAC_UNDERFLOW_COUNT_EN to build the underflow counter.
// Without it underflow_count is tied to 0 and no counter is built.

`timescale 1ns/1ps

// sync_fifo: generic single-clock FIFO with valid/ready on both sides.
// Latency: a pushed word is visible at rd_dat the cycle after the push; no write-to-read bypass.
// Backpressure: wr_rdy is low while full; rd_vld is low while empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  // Flags come straight from the count register, so an empty FIFO never
  // offers the word being written in the same cycle.
  assign wr_rdy = (count < CW'(DEPTH));
  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign push   = wr_vld & wr_rdy;
  assign pop    = rd_rdy & rd_vld;

  // DEPTH is a power of two, so the pointers wrap modulo DEPTH on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end
endmodule

// audio_dac_serializer: FIFO plus I2S transmit state machine.
// Latency: pop on the synchronized LRCK fall (3 CLOCK_50 cycles after the pin), bit 23 on the next BCLK fall.
// Backpressure: write is ignored while write_ready is low; underflow frames are sent as zeros.
module audio_dac_serializer #(
  parameter int DEPTH = 4
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        write,
  input  logic [23:0] writedata_left,
  input  logic [23:0] writedata_right,
  output logic        write_ready,
  input  logic        AUD_BCLK,
  input  logic        AUD_DACLRCK,
  output logic        AUD_DACDAT,
  output logic        underflow,
  output logic [15:0] underflow_count
);
  typedef struct packed {
    logic [23:0] left;
    logic [23:0] right;
  } pair_t;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    LEFT,
    RIGHT
  } state_t;

  // Codec clock synchronizers: [0] metastability stage, [1] synchronized,
  // [2] history used for edge detection.
  logic [2:0] bclk_sr;
  logic [2:0] lrck_sr;
  logic       bclk_fall;
  logic       lrck_fall;
  logic       lrck_rise;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sr <= '0;
      lrck_sr <= '0;
    end else begin
      bclk_sr <= {bclk_sr[1:0], AUD_BCLK};
      lrck_sr <= {lrck_sr[1:0], AUD_DACLRCK};
    end
  end

  assign bclk_fall =  bclk_sr[2] & ~bclk_sr[1];
  assign lrck_fall =  lrck_sr[2] & ~lrck_sr[1];
  assign lrck_rise = ~lrck_sr[2] &  lrck_sr[1];

  // Sample FIFO: one pop per frame, taken on the LRCK falling edge.
  pair_t wr_pair;
  pair_t head;
  logic  fifo_vld;
  logic  uf_event;

  assign wr_pair.left  = writedata_left;
  assign wr_pair.right = writedata_right;

  sync_fifo #(
    .W     ($bits(pair_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (CLOCK_50),
    .rst_n  (reset_n),
    .wr_vld (write),
    .wr_rdy (write_ready),
    .wr_dat (wr_pair),
    .rd_vld (fifo_vld),
    .rd_rdy (lrck_fall),
    .rd_dat (head)
  );

  assign uf_event = lrck_fall & ~fifo_vld;

  // Transmit FSM. The shift register itself acts as the left holding
  // register: the left sample goes straight into it at frame start, while
  // the right sample waits in right_hold until the LRCK rising edge.
  state_t      state;
  logic [23:0] shift;
  logic [23:0] right_hold;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= WAIT_FRAME;
      shift      <= '0;
      right_hold <= '0;
      AUD_DACDAT <= 1'b0;
      underflow  <= 1'b0;
    end else if (lrck_fall) begin
      // The LRCK edge takes priority over a coincident BCLK fall, so the
      // first BCLK fall after the edge carries bit 23 (one-bit I2S delay).
      state      <= LEFT;
      AUD_DACDAT <= 1'b0;
      if (fifo_vld) begin
        shift      <= head.left;
        right_hold <= head.right;
      end else begin
        shift      <= '0;
        right_hold <= '0;
        underflow  <= 1'b1;
      end
    end else begin
      case (state)
        WAIT_FRAME: begin
          AUD_DACDAT <= 1'b0;
        end
        LEFT: begin
          if (lrck_rise) begin
            state      <= RIGHT;
            shift      <= right_hold;
            AUD_DACDAT <= 1'b0;
          end else if (bclk_fall) begin
            AUD_DACDAT <= shift[23];
            shift      <= {shift[22:0], 1'b0};
          end
        end
        RIGHT: begin
          // Zero-fill means the slots after bit 0 read back as 0 until
          // the next frame starts.
          if (bclk_fall) begin
            AUD_DACDAT <= shift[23];
            shift      <= {shift[22:0], 1'b0};
          end
        end
        default: begin
          state      <= WAIT_FRAME;
          AUD_DACDAT <= 1'b0;
        end
      endcase
    end
  end

`ifdef DAC_UNDERFLOW_COUNT_EN
  logic [15:0] uf_cnt;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      uf_cnt <= '0;
    end else if (uf_event && (uf_cnt != 16'hFFFF)) begin
      uf_cnt <= uf_cnt + 16'd1;
    end
  end

  assign underflow_count = uf_cnt;
`else
  logic unused_uf_event;

  assign unused_uf_event = uf_event;
  assign underflow_count = 16'd0;
`endif
endmodule

// File: tb/tb_audio_dac_serializer.sv
`timescale 1ns/1ps

module tb_audio_dac_serializer;
  logic        CLOCK_50;
  logic        reset_n;
  logic        write;
  logic [23:0] writedata_left;
  logic [23:0] writedata_right;
  logic        write_ready;
  logic        AUD_BCLK;
  logic        AUD_DACLRCK;
  logic        AUD_DACDAT;
  logic        underflow;
  logic [15:0] underflow_count;

`ifdef DAC_UNDERFLOW_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  audio_dac_serializer dut (
    .CLOCK_50        (CLOCK_50),
    .reset_n         (reset_n),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .write_ready     (write_ready),
    .AUD_BCLK        (AUD_BCLK),
    .AUD_DACLRCK     (AUD_DACLRCK),
    .AUD_DACDAT      (AUD_DACDAT),
    .underflow       (underflow),
    .underflow_count (underflow_count)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        push;
    logic [23:0] l;
    logic [23:0] r;
    logic [31:0] exp_l;   // 32 sampled slots of the left half, MSB = first slot
    logic [31:0] exp_r;
    logic        exp_uf;
  } vec_t;

  vec_t        vecs [5];
  logic [31:0] lc;
  logic [31:0] rc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] half_of(input logic [23:0] s);
    // slot 0 is the I2S delay bit, then 24 data bits, then 7 zero slots
    half_of = {1'b0, s, 7'b0};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);
  endtask

  task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
    @(negedge CLOCK_50);
    write           = 1'b1;
    writedata_left  = l;
    writedata_right = r;
    @(negedge CLOCK_50);
    write = 1'b0;
  endtask

  // One codec frame: 64 BCLK periods of 320 ns, LRCK changing on BCLK falls.
  // DACDAT is sampled just before each BCLK rise. abort_at >= 0 asserts
  // reset at that slot of the left half and abandons the frame.
  task automatic run_frame(input int abort_at, output logic [31:0] lcap, output logic [31:0] rcap);
    lcap = '0;
    rcap = '0;
    @(negedge CLOCK_50);
    #3;
    for (int h = 0; h < 2; h++) begin
      for (int i = 0; i < 32; i++) begin
        AUD_BCLK = 1'b0;
        if (i == 0) AUD_DACLRCK = (h == 1);
        if (h == 0 && i == abort_at) begin
          #80;
          reset_n     = 1'b0;
          AUD_BCLK    = 1'b1;
          AUD_DACLRCK = 1'b1;
          return;
        end
        #159;
        if (h == 0) lcap = {lcap[30:0], AUD_DACDAT};
        else        rcap = {rcap[30:0], AUD_DACDAT};
        #1;
        AUD_BCLK = 1'b1;
        #160;
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    logic        acc;
    logic [23:0] pl [9];
    logic [23:0] pr [9];

    reset_n         = 1'b0;
    write           = 1'b0;
    writedata_left  = '0;
    writedata_right = '0;
    AUD_BCLK        = 1'b1;
    AUD_DACLRCK     = 1'b1;

    vecs[0] = '{1'b1, 24'hA5A5A5, 24'h5A5A5A, 32'h52D2D280, 32'h2D2D2D00, 1'b0};
    vecs[1] = '{1'b1, 24'h800000, 24'h7FFFFF, 32'h40000000, 32'h3FFFFF80, 1'b0};
    vecs[2] = '{1'b1, 24'hFFFFFF, 24'h000001, 32'h7FFFFF80, 32'h00000080, 1'b0};
    vecs[3] = '{1'b1, 24'h123456, 24'hABCDEF, 32'h091A2B00, 32'h55E6F780, 1'b0};
    vecs[4] = '{1'b0, 24'h000000, 24'h000000, 32'h00000000, 32'h00000000, 1'b1};

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    check("rst_write_ready", 32'(write_ready), 32'd1);
    check("rst_dacdat", 32'(AUD_DACDAT), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_uf_count", 32'(underflow_count), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // Table: one push (or none) then one frame each
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].push) push_pair(vecs[i].l, vecs[i].r);
      run_frame(-1, lc, rc);
      check($sformatf("vec%0d_left", i), lc, vecs[i].exp_l);
      check($sformatf("vec%0d_right", i), rc, vecs[i].exp_r);
      check($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].exp_uf));
    end
    check("vec_uf_count", 32'(underflow_count), CNT_EN ? 32'd1 : 32'd0);

    // Fill to DEPTH with no LRCK, extra write ignored
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_pair(vecs[i].l, vecs[i].r);
      check($sformatf("full_ready_after_push%0d", i + 1), 32'(write_ready), (i < 3) ? 32'd1 : 32'd0);
    end
    push_pair(24'hDEADBE, 24'hEF0123);
    check("full_ready_after_ignored", 32'(write_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      run_frame(-1, lc, rc);
      check($sformatf("full_drain%0d_left", i), lc, vecs[i].exp_l);
      check($sformatf("full_drain%0d_right", i), rc, vecs[i].exp_r);
      if (i == 0) check("full_ready_after_pop", 32'(write_ready), 32'd1);
    end
    run_frame(-1, lc, rc);
    check("full_ignored_not_sent", lc | rc, 32'd0);
    check("full_uf_after_drain", 32'(underflow), 32'd1);

    // No pushes, three frames
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_frame(-1, lc, rc);
      check($sformatf("empty_frame%0d", i), lc | rc, 32'd0);
    end
    check("empty_underflow", 32'(underflow), 32'd1);
    check("empty_uf_count", 32'(underflow_count), CNT_EN ? 32'd3 : 32'd0);

    // Reset at bit 10 of the left half with 2 pairs queued
    push_pair(vecs[0].l, vecs[0].r);
    push_pair(vecs[1].l, vecs[1].r);
    run_frame(11, lc, rc);
    #100;
    check("midrst_write_ready", 32'(write_ready), 32'd1);
    check("midrst_dacdat", 32'(AUD_DACDAT), 32'd0);
    check("midrst_underflow", 32'(underflow), 32'd0);
    check("midrst_uf_count", 32'(underflow_count), 32'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    acc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      AUD_BCLK = 1'b0;
      #160;
      acc = acc | AUD_DACDAT;
      AUD_BCLK = 1'b1;
      #160;
    end
    check("midrst_idle_zero", 32'(acc), 32'd0);
    push_pair(vecs[2].l, vecs[2].r);
    run_frame(-1, lc, rc);
    check("midrst_left", lc, vecs[2].exp_l);
    check("midrst_right", rc, vecs[2].exp_r);
    check("midrst_no_underflow", 32'(underflow), 32'd0);
    run_frame(-1, lc, rc);
    check("midrst_queue_flushed", lc | rc, 32'd0);

    // Write on the same cycle the LRCK fall is seen, FIFO empty: no bypass
    do_reset();
    fork
      run_frame(-1, lc, rc);
      begin
        @(negedge CLOCK_50);   // frame start; LRCK falls 3 ns later
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        write           = 1'b1;
        writedata_left  = 24'h654321;
        writedata_right = 24'hFEDCBA;
        @(negedge CLOCK_50);
        write = 1'b0;
      end
    join
    check("samecyc_frame_zero", lc | rc, 32'd0);
    check("samecyc_underflow", 32'(underflow), 32'd1);
    check("samecyc_uf_count", 32'(underflow_count), CNT_EN ? 32'd1 : 32'd0);
    run_frame(-1, lc, rc);
    check("samecyc_next_left", lc, 32'h32A19080);
    check("samecyc_next_right", rc, 32'h7F6E5D00);

    // Nine pairs interleaved with nine frames, two kept in flight
    do_reset();
    for (int i = 0; i < 9; i++) begin
      pl[i] = 24'h010101 * 24'(i + 1);
      pr[i] = ~pl[i];
    end
    push_pair(pl[0], pr[0]);
    push_pair(pl[1], pr[1]);
    for (int i = 0; i < 9; i++) begin
      if (i + 2 < 9) push_pair(pl[i + 2], pr[i + 2]);
      run_frame(-1, lc, rc);
      check($sformatf("wrap%0d_left", i), lc, half_of(pl[i]));
      check($sformatf("wrap%0d_right", i), rc, half_of(pr[i]));
    end
    check("wrap_no_underflow", 32'(underflow), 32'd0);
    check("wrap_uf_count", 32'(underflow_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
